// File: rtl/atm_pkg.sv
// Shared types for the ATM ledger arbiter: opcodes, completion status and FSM states.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_BAL = 2'b00,
    OP_WDR = 2'b01,
    OP_DEP = 2'b10,
    OP_XFR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_NSF = 2'b01,
    ST_OVF = 2'b10,
    ST_TMO = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    XFER = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/atm_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module atm_rr_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         winner,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan N_REQ positions starting at ptr; the first set request wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/atm_ledger_arbiter.sv
// Shared account-balance ledger: round-robin access for N_REQ terminals, one atomic
// read-modify-write transaction at a time, transfers handed to the interbank link.
module atm_ledger_arbiter
  import atm_pkg::*;
#(
  parameter int unsigned       N_REQ        = 4,
  parameter int unsigned       AMT_W        = 32,
  parameter logic [AMT_W-1:0]  INIT_BALANCE = 32'h000186A0,
  parameter int unsigned       XFER_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [2*N_REQ-1:0]      op,
  input  logic [AMT_W*N_REQ-1:0]  amount,
  output logic [N_REQ-1:0]        gnt,
  output logic                    done,
  output logic [1:0]              status,
  output logic [AMT_W-1:0]        balance_out,
  output logic                    xfer_valid,
  output logic [AMT_W-1:0]        xfer_amount,
  input  logic                    xfer_ready
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = (XFER_TIMEOUT > 1) ? $clog2(XFER_TIMEOUT) : 1;

  state_e             state_q,     state_d;
  logic [AMT_W-1:0]   balance_q,   balance_d;
  logic [IDX_W-1:0]   ptr_q,       ptr_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  op_e                op_q,        op_d;
  logic [AMT_W-1:0]   amt_q,       amt_d;
  logic [N_REQ-1:0]   gnt_q,       gnt_d;
  logic               done_q,      done_d;
  status_e            status_q,    status_d;
  logic [AMT_W-1:0]   bal_out_q,   bal_out_d;
  logic               xv_q,        xv_d;
  logic [AMT_W-1:0]   xa_q,        xa_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;

  logic [1:0]         op_arr  [N_REQ];
  logic [AMT_W-1:0]   amt_arr [N_REQ];
  logic [N_REQ-1:0]   win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic [AMT_W:0]     dep_sum;

  atm_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req    (req),
    .ptr    (ptr_q),
    .winner (win_onehot),
    .idx    (win_idx)
  );

  // Split the flat per-terminal buses into indexable arrays.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      op_arr[i]  = op[2*i +: 2];
      amt_arr[i] = amount[AMT_W*i +: AMT_W];
    end
  end

  assign dep_sum = {1'b0, balance_q} + {1'b0, amt_q};

  // Next-state logic for the transaction FSM, ledger and registered outputs.
  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    op_d      = op_q;
    amt_d     = amt_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    status_d  = status_q;
    bal_out_d = bal_out_q;
    xv_d      = xv_q;
    xa_d      = xa_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          idx_d   = win_idx;
          op_d    = op_e'(op_arr[win_idx]);
          amt_d   = amt_arr[win_idx];
          gnt_d   = win_onehot;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
        done_d  = 1'b1;
        unique case (op_q)
          OP_BAL: status_d = ST_OK;
          OP_WDR: begin
            if (amt_q <= balance_q) begin
              balance_d = balance_q - amt_q;
              status_d  = ST_OK;
            end else begin
              status_d  = ST_NSF;
            end
          end
          OP_DEP: begin
            if (dep_sum[AMT_W]) begin
              status_d  = ST_OVF;
            end else begin
              balance_d = dep_sum[AMT_W-1:0];
              status_d  = ST_OK;
            end
          end
          OP_XFR: begin
            if (amt_q > balance_q) begin
              status_d = ST_NSF;
            end else begin
              state_d = XFER;
              done_d  = 1'b0;
              xv_d    = 1'b1;
              xa_d    = amt_q;
              cnt_d   = '0;
            end
          end
        endcase
      end
      XFER: begin
        // Acceptance takes priority, so ready on the final counted cycle still debits.
        if (xfer_ready) begin
          balance_d = balance_q - amt_q;
          status_d  = ST_OK;
          xv_d      = 1'b0;
          done_d    = 1'b1;
          state_d   = RESP;
        end else if (cnt_q == CNT_W'(XFER_TIMEOUT - 1)) begin
          status_d  = ST_TMO;
          xv_d      = 1'b0;
          done_d    = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d     = cnt_q + 1'b1;
        end
      end
      RESP: begin
        gnt_d   = '0;
        ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done_d) begin
      bal_out_d = balance_d;
    end
  end

  // State and output registers; reset aborts any transaction and reloads the balance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      balance_q <= INIT_BALANCE;
      ptr_q     <= '0;
      idx_q     <= '0;
      op_q      <= OP_BAL;
      amt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      status_q  <= ST_OK;
      bal_out_q <= INIT_BALANCE;
      xv_q      <= 1'b0;
      xa_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      status_q  <= status_d;
      bal_out_q <= bal_out_d;
      xv_q      <= xv_d;
      xa_q      <= xa_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign status      = status_q;
  assign balance_out = bal_out_q;
  assign xfer_valid  = xv_q;
  assign xfer_amount = xa_q;

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Scoreboard bench for atm_ledger_arbiter: drivers push expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_atm_ledger_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam logic [31:0] INIT = 32'd100000;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  op = '0;
  logic [W*N-1:0]  amount = '0;
  logic [N-1:0]    gnt;
  logic            done;
  logic [1:0]      status;
  logic [W-1:0]    balance_out;
  logic            xfer_valid;
  logic [W-1:0]    xfer_amount;
  logic            xfer_ready = 1'b0;

  typedef struct packed {
    logic [3:0]  g;
    logic [1:0]  s;
    logic [31:0] b;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  atm_ledger_arbiter #(
    .N_REQ(N), .AMT_W(W), .INIT_BALANCE(32'h000186A0), .XFER_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset_n), .req(req), .op(op), .amount(amount),
    .gnt(gnt), .done(done), .status(status), .balance_out(balance_out),
    .xfer_valid(xfer_valid), .xfer_amount(xfer_amount), .xfer_ready(xfer_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done gnt=%b", gnt);
      end else begin
        mon_e = sbq.pop_front();
        chk("done_gnt", 64'(gnt), 64'(mon_e.g));
        chk("done_status", 64'(status), 64'(mon_e.s));
        chk("done_balance", 64'(balance_out), 64'(mon_e.b));
      end
    end
  end

  task automatic drive(input int t, input logic [1:0] o, input logic [31:0] a);
    req[t]            = 1'b1;
    op[2*t +: 2]      = o;
    amount[W*t +: W]  = a;
  endtask

  // Issue one transaction, wait (bounded) for its done, then drop the request.
  task automatic run_txn(input int t, input logic [1:0] o, input logic [31:0] a,
                         input logic [3:0] eg, input logic [1:0] es, input logic [31:0] eb,
                         output int lat);
    exp_t e;
    e.g = eg; e.s = es; e.b = eb;
    sbq.push_back(e);
    drive(t, o, a);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (done !== 1'b1 && lat < 60);
    if (done !== 1'b1) chk("txn_timeout", 64'(0), 64'(1));
    req[t] = 1'b0;
  endtask

  task automatic wait_xv(output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (xfer_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("xfer_valid_wait", 64'(0), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    int  n;
    bit  ok;

    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_xfer_valid", 64'(xfer_valid), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_status", 64'(status), 64'(0));
    chk("rst_balance_out", 64'(balance_out), 64'(INIT));
    chk("rst_xfer_amount", 64'(xfer_amount), 64'(0));

    // 1: drain the account exactly, then an overdraft attempt
    run_txn(0, 2'b01, 32'd100000, 4'b0001, 2'b00, 32'd0, lat);
    chk("latency_t_plus_2", 64'(lat), 64'(2));
    run_txn(0, 2'b01, 32'd1, 4'b0001, 2'b01, 32'd0, lat);

    // 2: deposits, overflow, exact-max boundary, zero amount
    run_txn(1, 2'b10, 32'd100000, 4'b0010, 2'b00, 32'd100000, lat);
    run_txn(1, 2'b10, 32'hFFFFFFFF, 4'b0010, 2'b10, 32'd100000, lat);
    run_txn(1, 2'b10, 32'd5, 4'b0010, 2'b00, 32'd100005, lat);
    run_txn(1, 2'b01, 32'd5, 4'b0010, 2'b00, 32'd100000, lat);
    run_txn(1, 2'b10, 32'hFFFE795F, 4'b0010, 2'b00, 32'hFFFFFFFF, lat);
    run_txn(1, 2'b01, 32'hFFFE795F, 4'b0010, 2'b00, 32'd100000, lat);
    run_txn(3, 2'b10, 32'd0, 4'b1000, 2'b00, 32'd100000, lat);

    // 3: all four request together; pointer is back at 0
    op  = '0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.g = 4'(1 << (i % 4)); e.s = 2'b00; e.b = 32'd100000;
      sbq.push_back(e);
    end
    n = 0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    req = '0;
    chk("rr_done_count", 64'(n), 64'(5));

    // 4: transfer accepted on the third XFER cycle; late op/amount/req changes ignored
    begin
      exp_t e;
      e.g = 4'b0100; e.s = 2'b00; e.b = 32'd99500;
      sbq.push_back(e);
    end
    drive(2, 2'b11, 32'd500);
    wait_xv(ok);
    chk("xfer_amount", 64'(xfer_amount), 64'(500));
    chk("xfer_gnt", 64'(gnt), 64'(4'b0100));
    req[2] = 1'b0;
    op[5:4] = 2'b00;
    amount[W*2 +: W] = 32'd7;
    @(negedge clk);
    @(negedge clk);
    chk("xfer_amount_stable", 64'(xfer_amount), 64'(500));
    xfer_ready = 1'b1;
    @(negedge clk);
    xfer_ready = 1'b0;
    chk("xfer_valid_after_accept", 64'(xfer_valid), 64'(0));
    chk("xfer_done_latency", 64'(done), 64'(1));
    repeat (2) @(negedge clk);

    // 5: transfer with no ready times out after 16 XFER cycles
    begin
      exp_t e;
      e.g = 4'b1000; e.s = 2'b11; e.b = 32'd99500;
      sbq.push_back(e);
    end
    drive(3, 2'b11, 32'd10);
    wait_xv(ok);
    n = 1;
    while (xfer_valid === 1'b1 && n < 40) begin
      @(negedge clk);
      if (xfer_valid === 1'b1) n++;
    end
    req[3] = 1'b0;
    chk("timeout_cycles", 64'(n), 64'(16));
    chk("timeout_xfer_valid", 64'(xfer_valid), 64'(0));
    repeat (2) @(negedge clk);

    // 6: asynchronous reset in the middle of a transfer
    drive(0, 2'b11, 32'd20);
    wait_xv(ok);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_xfer_valid", 64'(xfer_valid), 64'(0));
    chk("async_gnt", 64'(gnt), 64'(0));
    chk("async_done", 64'(done), 64'(0));
    req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_balance_out", 64'(balance_out), 64'(INIT));
    run_txn(1, 2'b00, 32'd0, 4'b0010, 2'b00, 32'd100000, lat);
    run_txn(0, 2'b01, 32'd20, 4'b0001, 2'b00, 32'd99980, lat);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
